// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
// The optional timeout (I2C_ARB_TIMEOUT_EN) uses TMR_W and TIMEOUT_CYC_DEF.
package i2c_arb_pkg;

    localparam int NREQ            = 2;
    localparam int TMR_W           = 20;
    localparam int TIMEOUT_CYC_DEF = 1_000_000;

    // Read-byte slot selected by the running byte count; FULL means further bytes are ignored.
    localparam logic [1:0] BYTE_HI   = 2'd0;
    localparam logic [1:0] BYTE_LO   = 2'd1;
    localparam logic [1:0] BYTE_FULL = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP,
        ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arbiter2
    import i2c_arb_pkg::*;
(
    input  logic [NREQ-1:0] Req_valid,
    input  logic            last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            case (Req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C Master between two requesters: arbitrate, issue, collect up to two bytes, respond.
// Define I2C_ARB_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYC cycles.
//
// state     | meaning
// IDLE      | arbitrate when Master ready; latch winning command
// ISSUE     | one-cycle M_start with latched command
// WAIT_BUSY | wait for Master to drop M_ready
// WAIT_DONE | capture read bytes and errors until M_ready returns
// RESP      | one-cycle tagged response to the owner
// DRAIN     | Master still busy after a forced response; no grants
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              Clk_in,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Req_valid,
    output logic [NREQ-1:0]   Req_ready,
    input  logic [NREQ*7-1:0] Req_adr,
    input  logic [NREQ*8-1:0] Req_pointer,
    input  logic [NREQ-1:0]   Req_set_pointer,
    input  logic [NREQ-1:0]   Req_r_w,
    input  logic [NREQ*16-1:0] Req_wdata,
    output logic [NREQ-1:0]   Rsp_valid,
    output logic              Rsp_error,
    output logic [15:0]       Rsp_data,
    output logic              M_start,
    output logic [6:0]        M_adr,
    output logic [7:0]        M_pointer,
    output logic              M_set_pointer,
    output logic              M_r_w,
    output logic [7:0]        M_data_in,
    output logic [7:0]        M_data_in2,
    input  logic              M_ready,
    input  logic              M_error,
    input  logic              M_data_valid,
    input  logic [7:0]        M_data_out
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << TMR_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 1 .. 2**TMR_W");
    end

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [NREQ-1:0]  owner_q, owner_d;
    logic [6:0]       adr_q, adr_d;
    logic [7:0]       ptr_q, ptr_d;
    logic             sp_q, sp_d;
    logic             rw_q, rw_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             err_q, err_d;
    logic             run_q, run_d;
    logic [NREQ-1:0]  grant;
    logic             gidx;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    // run_q keeps Req_ready low while reset is held and for the first cycle after release.
    rr_arbiter2 u_rr (
        .Req_valid  (Req_valid),
        .last_grant (last_grant_q),
        .enable     ((state_q == ST_IDLE) && M_ready && run_q),
        .grant      (grant)
    );

    assign gidx = grant[1];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        adr_d        = adr_q;
        ptr_d        = ptr_q;
        sp_d         = sp_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        byte_cnt_d   = byte_cnt_q;
        err_d        = err_q;
        run_d        = 1'b1;
        Req_ready    = grant;
        Rsp_valid    = '0;
        Rsp_error    = 1'b0;
        M_start      = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant != '0) begin
                    owner_d    = grant;
                    adr_d      = gidx ? Req_adr[13:7]      : Req_adr[6:0];
                    ptr_d      = gidx ? Req_pointer[15:8]  : Req_pointer[7:0];
                    sp_d       = gidx ? Req_set_pointer[1] : Req_set_pointer[0];
                    rw_d       = gidx ? Req_r_w[1]         : Req_r_w[0];
                    wdata_d    = gidx ? Req_wdata[31:16]   : Req_wdata[15:0];
                    rdata_d    = '0;
                    byte_cnt_d = BYTE_HI;
                    err_d      = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                M_start = 1'b1;
                state_d = ST_WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                tmr_d   = '0;
`endif
            end
            ST_WAIT_BUSY: begin
                if (M_error) err_d = 1'b1;
                if (!M_ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (M_error) err_d = 1'b1;
                if (M_data_valid) begin
                    if (byte_cnt_q == BYTE_HI) begin
                        rdata_d[15:8] = M_data_out;
                        byte_cnt_d    = BYTE_LO;
                    end else if (byte_cnt_q == BYTE_LO) begin
                        rdata_d[7:0]  = M_data_out;
                        byte_cnt_d    = BYTE_FULL;
                    end
                end
                if (M_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                Rsp_valid    = owner_q;
                Rsp_error    = err_q;
                last_grant_d = owner_q[1];
                state_d      = M_ready ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (M_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog overrides the normal wait transitions on its terminal cycle.
        if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMR_TC) begin
                state_d = ST_RESP;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= '0;
            adr_q        <= '0;
            ptr_q        <= '0;
            sp_q         <= 1'b0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            byte_cnt_q   <= BYTE_HI;
            err_q        <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            adr_q        <= adr_d;
            ptr_q        <= ptr_d;
            sp_q         <= sp_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            byte_cnt_q   <= byte_cnt_d;
            err_q        <= err_d;
            run_q        <= run_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) tmr_q <= '0;
        else      tmr_q <= tmr_d;
    end
`endif

    assign Rsp_data      = rdata_q;
    assign M_adr         = adr_q;
    assign M_pointer     = ptr_q;
    assign M_set_pointer = sp_q;
    assign M_r_w         = rw_q;
    assign M_data_in     = wdata_q[15:8];
    assign M_data_in2    = wdata_q[7:0];

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the bench acts as both requesters and the I2C Master.
module tb_i2c_master_arbiter;

    logic        Clk_in = 1'b0;
    logic        Rst;
    logic [1:0]  Req_valid;
    logic [1:0]  Req_ready;
    logic [13:0] Req_adr;
    logic [15:0] Req_pointer;
    logic [1:0]  Req_set_pointer;
    logic [1:0]  Req_r_w;
    logic [31:0] Req_wdata;
    logic [1:0]  Rsp_valid;
    logic        Rsp_error;
    logic [15:0] Rsp_data;
    logic        M_start;
    logic [6:0]  M_adr;
    logic [7:0]  M_pointer;
    logic        M_set_pointer;
    logic        M_r_w;
    logic [7:0]  M_data_in;
    logic [7:0]  M_data_in2;
    logic        M_ready;
    logic        M_error;
    logic        M_data_valid;
    logic [7:0]  M_data_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk_in = ~Clk_in;

    i2c_master_arbiter #(.TIMEOUT_CYC(100)) dut (
        .Clk_in          (Clk_in),
        .Rst             (Rst),
        .Req_valid       (Req_valid),
        .Req_ready       (Req_ready),
        .Req_adr         (Req_adr),
        .Req_pointer     (Req_pointer),
        .Req_set_pointer (Req_set_pointer),
        .Req_r_w         (Req_r_w),
        .Req_wdata       (Req_wdata),
        .Rsp_valid       (Rsp_valid),
        .Rsp_error       (Rsp_error),
        .Rsp_data        (Rsp_data),
        .M_start         (M_start),
        .M_adr           (M_adr),
        .M_pointer       (M_pointer),
        .M_set_pointer   (M_set_pointer),
        .M_r_w           (M_r_w),
        .M_data_in       (M_data_in),
        .M_data_in2      (M_data_in2),
        .M_ready         (M_ready),
        .M_error         (M_error),
        .M_data_valid    (M_data_valid),
        .M_data_out      (M_data_out)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, Req_ready, Rsp_valid, Rsp_error, Rsp_data, M_start, M_adr,
                M_pointer, M_set_pointer, M_r_w, M_data_in, M_data_in2};
    endfunction

    task automatic set_req(input int r, input logic [6:0] adr, input logic [7:0] ptr,
                           input logic sp, input logic rw, input logic [15:0] wd);
        Req_adr[r*7 +: 7]       = adr;
        Req_pointer[r*8 +: 8]   = ptr;
        Req_set_pointer[r]      = sp;
        Req_r_w[r]              = rw;
        Req_wdata[r*16 +: 16]   = wd;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp_gnt);
        int budget;
        budget = 0;
        while (Req_ready == 2'b00 && budget < 20) begin
            @(negedge Clk_in); #1;
            budget++;
        end
        check_val(tag, Req_ready, exp_gnt);
    endtask

    // Entered at a negedge+1 with the request(s) presented; returns at negedge+1 after RESP.
    task automatic run_txn(input logic [1:0] exp_gnt, input logic [6:0] e_adr, input logic [7:0] e_ptr,
                           input logic e_sp, input logic e_rw, input logic [15:0] e_wd,
                           input int nbytes, input logic [23:0] bytes, input bit coincide,
                           input bit inj_err, input logic [15:0] e_rdata, input bit drop);
        wait_grant("grant", exp_gnt);
        @(negedge Clk_in);
        if (drop) Req_valid = Req_valid & ~exp_gnt;
        #1;
        check_val("m_start", M_start, 1);
        check_val("ready_pulse", Req_ready, 0);
        check_val("m_cmd", {M_adr, M_pointer, M_set_pointer, M_r_w}, {e_adr, e_ptr, e_sp, e_rw});
        check_val("m_wdata", {M_data_in, M_data_in2}, e_wd);
        @(negedge Clk_in);
        M_ready = 1'b0;
        if (inj_err) M_error = 1'b1;
        #1;
        check_val("start_one", M_start, 0);
        @(negedge Clk_in);
        M_error = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            M_data_valid = 1'b1;
            M_data_out   = bytes[23-8*i -: 8];
            if (coincide && i == nbytes - 1) M_ready = 1'b1;
            @(negedge Clk_in);
            M_data_valid = 1'b0;
        end
        if (!(coincide && nbytes > 0)) begin
            M_ready = 1'b1;
            @(negedge Clk_in);
        end
        #1;
        check_val("rsp_valid", Rsp_valid, exp_gnt);
        check_val("rsp_data", Rsp_data, e_rdata);
        check_val("rsp_error", Rsp_error, inj_err);
        check_val("no_grant_resp", Req_ready, 0);
        @(negedge Clk_in); #1;
        check_val("rsp_one", Rsp_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        Rst = 1'b0;
        Req_valid = '0; Req_adr = '0; Req_pointer = '0; Req_set_pointer = '0;
        Req_r_w = '0; Req_wdata = '0;
        M_ready = 1'b1; M_error = 1'b0; M_data_valid = 1'b0; M_data_out = '0;
        repeat (3) @(negedge Clk_in);
        #1;
        check_val("reset_outs", all_outs(), 64'd0);

        // LM75 temperature read on requester 0, second byte coincides with M_ready rising.
        @(negedge Clk_in);
        Rst = 1'b1;
        set_req(0, 7'h48, 8'h00, 1'b0, 1'b1, 16'h0000);
        Req_valid = 2'b01;
        #1;
        run_txn(2'b01, 7'h48, 8'h00, 1'b0, 1'b1, 16'h0000, 2, 24'h198000, 1'b1, 1'b0, 16'h1980, 1'b1);

        // Register write on requester 1; Rsp_data cleared from previous read.
        set_req(1, 7'h48, 8'h03, 1'b0, 1'b0, 16'h5000);
        Req_valid = 2'b10;
        #1;
        run_txn(2'b10, 7'h48, 8'h03, 1'b0, 1'b0, 16'h5000, 0, 24'h0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Both held: alternate 0,1,0,1 with back-to-back grants.
        set_req(0, 7'h48, 8'h01, 1'b0, 1'b1, 16'h0000);
        set_req(1, 7'h4A, 8'h02, 1'b0, 1'b1, 16'h1234);
        Req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                run_txn(2'b01, 7'h48, 8'h01, 1'b0, 1'b1, 16'h0000, 1, {8'(8'h10 + i), 16'h0},
                        1'b0, 1'b0, {8'(8'h10 + i), 8'h00}, 1'b0);
            else
                run_txn(2'b10, 7'h4A, 8'h02, 1'b0, 1'b1, 16'h1234, 1, {8'(8'h10 + i), 16'h0},
                        1'b0, 1'b0, {8'(8'h10 + i), 8'h00}, 1'b0);
            if (i < 3) check_val("back2back", Req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // NACK on absent slave: error flagged, no data.
        Req_valid = 2'b00;
        set_req(0, 7'h4F, 8'h00, 1'b0, 1'b1, 16'h0000);
        Req_valid = 2'b01;
        #1;
        run_txn(2'b01, 7'h4F, 8'h00, 1'b0, 1'b1, 16'h0000, 0, 24'h0, 1'b0, 1'b1, 16'h0000, 1'b1);

        // Reset during WAIT_DONE; last_grant is 0 here so a surviving state would pick requester 1.
        set_req(1, 7'h4A, 8'h01, 1'b1, 1'b0, 16'hBEEF);
        Req_valid = 2'b10;
        #1;
        wait_grant("rst_grant", 2'b10);
        @(negedge Clk_in);
        Req_valid = 2'b00;
        @(negedge Clk_in);
        M_ready = 1'b0;
        @(negedge Clk_in);
        set_req(0, 7'h48, 8'h00, 1'b0, 1'b1, 16'h0000);
        Req_valid = 2'b11;
        M_data_valid = 1'b1;
        M_data_out = 8'h77;
        Rst = 1'b0;
        #1;
        check_val("midrst_outs", all_outs(), 64'd0);
        M_data_valid = 1'b0;
        @(negedge Clk_in);
        Rst = 1'b1;
        #1;
        check_val("rst_rel_outs", all_outs(), 64'd0);
        bad = 0;
        repeat (4) begin
            @(negedge Clk_in); #1;
            if (Rsp_valid != 2'b00 || Req_ready != 2'b00) bad++;
        end
        check_val("no_rsp_abort", bad, 0);
        M_ready = 1'b1;
        #1;
        run_txn(2'b01, 7'h48, 8'h00, 1'b0, 1'b1, 16'h0000, 1, 24'h210000, 1'b0, 1'b0, 16'h2100, 1'b1);
        run_txn(2'b10, 7'h4A, 8'h01, 1'b1, 1'b0, 16'hBEEF, 0, 24'h0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Third byte ignored; sticky error from the NACK does not carry over.
        set_req(1, 7'h4A, 8'h00, 1'b0, 1'b1, 16'h0000);
        Req_valid = 2'b10;
        #1;
        run_txn(2'b10, 7'h4A, 8'h00, 1'b0, 1'b1, 16'h0000, 3, 24'hAABBCC, 1'b0, 1'b0, 16'hAABB, 1'b1);

        // Request withdrawn while Master busy: dropped, no response.
        M_ready = 1'b0;
        Req_valid = 2'b01;
        bad = 0;
        repeat (3) begin
            #1;
            if (Req_ready != 2'b00) bad++;
            @(negedge Clk_in);
        end
        Req_valid = 2'b00;
        M_ready = 1'b1;
        repeat (5) begin
            @(negedge Clk_in); #1;
            if (Req_ready != 2'b00 || Rsp_valid != 2'b00 || M_start != 1'b0) bad++;
        end
        check_val("dropped_req", bad, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never finishes: forced error response 100 cycles after WAIT_BUSY entry, then DRAIN.
        set_req(0, 7'h48, 8'h00, 1'b0, 1'b1, 16'h0000);
        Req_valid = 2'b01;
        #1;
        wait_grant("to_grant", 2'b01);
        @(negedge Clk_in);
        Req_valid = 2'b00;
        #1;
        check_val("to_start", M_start, 1);
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk_in);
            if (k == 1) M_ready = 1'b0;
            #1;
            if (Rsp_valid != 2'b00) bad++;
        end
        check_val("to_early", bad, 0);
        @(negedge Clk_in); #1;
        check_val("to_rsp_valid", Rsp_valid, 2'b01);
        check_val("to_rsp_error", Rsp_error, 1);
        set_req(1, 7'h4A, 8'h05, 1'b0, 1'b0, 16'h0102);
        Req_valid = 2'b10;
        bad = 0;
        repeat (8) begin
            @(negedge Clk_in); #1;
            if (Req_ready != 2'b00 || Rsp_valid != 2'b00) bad++;
        end
        check_val("to_drain", bad, 0);
        M_ready = 1'b1;
        @(negedge Clk_in); #1;
        run_txn(2'b10, 7'h4A, 8'h05, 1'b0, 1'b0, 16'h0102, 0, 24'h0, 1'b0, 1'b0, 16'h0000, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
